// File: rtl/wrapper_ahb_packet_constructor.sv
`default_nettype none
//============================================================================
// Module      : wrapper_ahb_packet_constructor
// Description : AHB-Lite target that assembles sixteen 32-bit words into a
//               512-bit block for a hash core. Word 0 sits in the MSBs.
//               A write to word 15 completes the block. The block is then
//               held valid until the consumer takes it. Writes that arrive
//               while the block is held are stalled until the buffer is free.
//               Optional macro PKT_CONSTRUCTOR_SIZE_CHECK_EN: when defined,
//               transfers that are not word-sized get a two-cycle ERROR
//               response and change no state.
// Revision    : 1.0 - initial release
//============================================================================
module wrapper_ahb_packet_constructor #(
    parameter int ADDRWIDTH   = 12,
    parameter int PACKETWIDTH = 512
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic                   HSELS,
    input  logic [ADDRWIDTH-1:0]   HADDRS,
    input  logic [1:0]             HTRANSS,
    input  logic [2:0]             HSIZES,
    input  logic                   HWRITES,
    input  logic                   HREADYS,
    input  logic [31:0]            HWDATAS,
    output logic                   HREADYOUTS,
    output logic                   HRESPS,
    output logic [31:0]            HRDATAS,
    output logic [PACKETWIDTH-1:0] packet_data,
    output logic                   packet_data_last,
    output logic                   packet_data_valid,
    input  logic                   packet_data_ready
);

    localparam int c_WORDS = 16;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  word_cnt_q, word_cnt_d;
    logic        last_q, last_d;
    logic [31:0] buf_q [c_WORDS];

    logic        dp_valid_q;
    logic        dp_write_q;
    logic [7:0]  dp_addr_q;

    logic        w_err_cyc1;
    logic        w_err_cyc2;
    logic        w_err_any;
    logic        w_stall;
    logic        w_wr_done;
    logic        w_buf_wr;
    logic        w_rd;
    logic        w_handshake;
    logic [3:0]  w_idx;
    logic [31:0] w_status;
    logic        w_unused;

    // Capture the address phase of every transfer accepted on the bus
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 8'h00;
        end else if (HREADYS) begin
            dp_valid_q <= HSELS & HTRANSS[1];
            dp_write_q <= HWRITES;
            dp_addr_q  <= HADDRS[7:0];
        end
    end

`ifdef PKT_CONSTRUCTOR_SIZE_CHECK_EN
    logic [2:0] size_q;
    logic       err_q;

    // Track transfer size; err_q marks the second cycle of an ERROR response
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            size_q <= 3'b010;
            err_q  <= 1'b0;
        end else begin
            if (HREADYS) begin
                size_q <= HSIZES;
            end
            err_q <= w_err_cyc1;
        end
    end

    assign w_err_cyc1 = dp_valid_q & (size_q != 3'b010) & ~err_q;
    assign w_err_cyc2 = err_q;
    assign w_unused   = ^{HADDRS[ADDRWIDTH-1:8], HTRANSS[0]};
`else
    assign w_err_cyc1 = 1'b0;
    assign w_err_cyc2 = 1'b0;
    assign w_unused   = ^{HADDRS[ADDRWIDTH-1:8], HTRANSS[0], HSIZES};
`endif

    assign w_err_any   = w_err_cyc1 | w_err_cyc2;
    assign w_idx       = dp_addr_q[5:2];
    assign w_stall     = dp_valid_q & dp_write_q & ~w_err_any & (state_q == ST_HOLD);
    assign w_wr_done   = dp_valid_q & dp_write_q & ~w_err_any & (state_q == ST_FILL);
    assign w_buf_wr    = w_wr_done & ~dp_addr_q[7];
    assign w_rd        = dp_valid_q & ~dp_write_q & ~w_err_any;
    assign w_handshake = (state_q == ST_HOLD) & packet_data_ready;
    assign w_status    = {27'b0, packet_data_valid, word_cnt_q};

    // State, word count and last flag registers
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_FILL;
            word_cnt_q <= 4'd0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            last_q     <= last_d;
        end
    end

    // Next-state logic and bus responses
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        last_d     = last_q;
        HREADYOUTS = 1'b1;
        HRESPS     = 1'b0;
        HRDATAS    = 32'h0;

        case (state_q)
            ST_FILL: begin
                if (w_buf_wr && (w_idx == 4'd15)) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_handshake) begin
                    state_d    = ST_FILL;
                    word_cnt_d = 4'd0;
                    last_d     = 1'b0;
                end
            end
            default: state_d = ST_FILL;
        endcase

        // Buffer writes complete only in FILL, so they never meet the handshake.
        // The count saturates so a full block reads back as 15 in STATUS.
        if (w_buf_wr) begin
            if (word_cnt_q != 4'd15) begin
                word_cnt_d = word_cnt_q + 4'd1;
            end
            if (dp_addr_q[6]) begin
                last_d = 1'b1;
            end
        end

        if (w_err_cyc2) begin
            HRESPS = 1'b1;
        end else if (w_err_cyc1) begin
            HREADYOUTS = 1'b0;
            HRESPS     = 1'b1;
        end else if (w_stall) begin
            HREADYOUTS = 1'b0;
        end

        if (w_rd) begin
            if (!dp_addr_q[7]) begin
                HRDATAS = buf_q[w_idx];
            end else if (dp_addr_q == 8'h80) begin
                HRDATAS = w_status;
            end
        end
    end

    // Block buffer; cleared only by reset
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < c_WORDS; i++) begin
                buf_q[i] <= 32'h0;
            end
        end else if (w_buf_wr) begin
            buf_q[w_idx] <= HWDATAS;
        end
    end

    generate
        for (genvar g = 0; g < c_WORDS; g++) begin : g_pack
            assign packet_data[PACKETWIDTH-1-32*g -: 32] = buf_q[g];
        end
    endgenerate

    assign packet_data_valid = (state_q == ST_HOLD);
    assign packet_data_last  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_wrapper_ahb_packet_constructor.sv
`default_nettype none
//============================================================================
// Module      : tb_wrapper_ahb_packet_constructor
// Description : Scoreboard bench for the AHB packet constructor. The driver
//               pushes expected read data, error responses and packets into
//               queues. A monitor pops and compares these when the bus or
//               packet port presents them.
//               The bench honours PKT_CONSTRUCTOR_SIZE_CHECK_EN.
// Revision    : 1.0 - initial release
//============================================================================
module tb_wrapper_ahb_packet_constructor;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic         HSELS;
    logic [11:0]  HADDRS;
    logic [1:0]   HTRANSS;
    logic [2:0]   HSIZES;
    logic         HWRITES;
    logic         HREADYS;
    logic [31:0]  HWDATAS;
    logic         HREADYOUTS;
    logic         HRESPS;
    logic [31:0]  HRDATAS;
    logic [511:0] packet_data;
    logic         packet_data_last;
    logic         packet_data_valid;
    logic         packet_data_ready;

    assign HREADYS = HREADYOUTS;

    always #5 HCLK = ~HCLK;

    wrapper_ahb_packet_constructor #(
        .ADDRWIDTH   (12),
        .PACKETWIDTH (512)
    ) dut (
        .HCLK              (HCLK),
        .HRESET            (HRESET),
        .HSELS             (HSELS),
        .HADDRS            (HADDRS),
        .HTRANSS           (HTRANSS),
        .HSIZES            (HSIZES),
        .HWRITES           (HWRITES),
        .HREADYS           (HREADYS),
        .HWDATAS           (HWDATAS),
        .HREADYOUTS        (HREADYOUTS),
        .HRESPS            (HRESPS),
        .HRDATAS           (HRDATAS),
        .packet_data       (packet_data),
        .packet_data_last  (packet_data_last),
        .packet_data_valid (packet_data_valid),
        .packet_data_ready (packet_data_ready)
    );

    typedef struct {
        bit          is_err;
        logic [31:0] data;
    } rsp_t;

    rsp_t         rsp_q[$];
    logic [512:0] pkt_q[$];
    logic [31:0]  ew[16];
    int           n_vec  = 0;
    int           n_miss = 0;

    function void chk32(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    // Pack the expected words (word 0 in the MSBs) with the expected last flag
    function void push_pkt(bit last);
        logic [512:0] p;
        p = '0;
        p[512] = last;
        for (int i = 0; i < 16; i++) begin
            p[511-32*i -: 32] = ew[i];
        end
        pkt_q.push_back(p);
    endfunction

    // ---------------- monitor ----------------
    bit           dp_v, dp_w, err2, prev_v;
    int           hold_len, last_hold;
    logic [511:0] snap;
    logic         snap_last;
    rsp_t         r;
    logic [512:0] p;

    initial begin
        dp_v = 0; dp_w = 0; err2 = 0; prev_v = 0; hold_len = 0; last_hold = 0;
    end

    always @(negedge HCLK) begin
        if (HRESET) begin
            dp_v = 0; err2 = 0; prev_v = 0;
        end else begin
            if (packet_data_valid) begin
                if (!prev_v) begin
                    snap = packet_data; snap_last = packet_data_last; hold_len = 1;
                end else begin
                    hold_len++;
                    n_vec++;
                    if (packet_data !== snap || packet_data_last !== snap_last) begin
                        n_miss++;
                        $display("FAIL hold_stable: data/last changed while valid (last got %b want %b)",
                                 packet_data_last, snap_last);
                    end
                end
                if (packet_data_ready) begin
                    last_hold = hold_len;
                    n_vec++;
                    if (pkt_q.size() == 0) begin
                        n_miss++;
                        $display("FAIL packet: got unexpected packet, want none");
                    end else begin
                        p = pkt_q.pop_front();
                        if (packet_data !== p[511:0] || packet_data_last !== p[512]) begin
                            n_miss++;
                            $display("FAIL packet: got %h last %b want %h last %b",
                                     packet_data[511:384], packet_data_last, p[511:384], p[512]);
                        end
                    end
                end
            end
            prev_v = packet_data_valid;

            if (err2) begin
                chk32("err_cycle2 {ready,resp}", {30'd0, HREADYOUTS, HRESPS}, 32'd3);
                err2 = 0;
                dp_v = 0;
            end else if (dp_v && HRESPS && !HREADYOUTS) begin
                n_vec++;
                if (rsp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL error_resp: got ERROR, want none");
                end else begin
                    r = rsp_q.pop_front();
                    if (!r.is_err) begin
                        n_miss++;
                        $display("FAIL error_resp: got ERROR, want read data %h", r.data);
                    end
                end
                err2 = 1;
            end else if (dp_v && HREADYOUTS) begin
                chk32("okay_resp", {31'd0, HRESPS}, 32'd0);
                if (!dp_w) begin
                    if (rsp_q.size() == 0) begin
                        n_vec++; n_miss++;
                        $display("FAIL read: got %h, want no read", HRDATAS);
                    end else begin
                        r = rsp_q.pop_front();
                        if (r.is_err) begin
                            n_vec++; n_miss++;
                            $display("FAIL read: got OKAY %h, want ERROR", HRDATAS);
                        end else begin
                            chk32("read_data", HRDATAS, r.data);
                        end
                    end
                end
                dp_v = 0;
            end

            if (HREADYOUTS) begin
                dp_v = HSELS & HTRANSS[1];
                dp_w = HWRITES;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic xfer(input bit w, input logic [7:0] a, input logic [31:0] d,
                        input logic [2:0] sz, output int stalls);
        bit done;
        @(posedge HCLK); #1;
        HSELS = 1'b1; HTRANSS = 2'b10; HWRITES = w; HADDRS = {4'h0, a}; HSIZES = sz;
        @(posedge HCLK); #1;
        HSELS = 1'b0; HTRANSS = 2'b00; HWDATAS = d;
        stalls = 0;
        done = 0;
        while (!done) begin
            @(negedge HCLK);
            if (HREADYOUTS) begin
                done = 1;
            end else begin
                stalls++;
                if (stalls > 60) begin
                    n_vec++; n_miss++;
                    $display("FAIL xfer_timeout: got HREADYOUTS=0 for %0d cycles, want completion", stalls);
                    done = 1;
                end
            end
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        int st;
        xfer(1'b1, a, d, 3'b010, st);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp);
        int st;
        rsp_q.push_back('{is_err: 1'b0, data: exp});
        xfer(1'b0, a, 32'h0, 3'b010, st);
    endtask

    // Write words first..lastw with base+i; word 15 goes to 0x7C when lastf
    task automatic fill(input logic [31:0] base, input bit lastf, input int first, input int lastw);
        for (int i = first; i <= lastw; i++) begin
            ew[i] = base + i;
            wr(((i == 15 && lastf) ? 8'h40 : 8'h00) + 8'(4 * i), base + i);
        end
    endtask

    // ---------------- stimulus ----------------
    int st;

    initial begin
        HRESET = 1'b1; HSELS = 0; HADDRS = 0; HTRANSS = 0; HSIZES = 3'b010;
        HWRITES = 0; HWDATAS = 0; packet_data_ready = 1'b1;
        #12;
        chk32("reset HREADYOUTS", {31'd0, HREADYOUTS}, 32'd1);
        chk32("reset HRESPS", {31'd0, HRESPS}, 32'd0);
        chk32("reset HRDATAS", HRDATAS, 32'd0);
        chk32("reset valid", {31'd0, packet_data_valid}, 32'd0);
        chk32("reset last", {31'd0, packet_data_last}, 32'd0);
        chk32("reset packet_data nonzero", {31'd0, |packet_data}, 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        // Basic packet: words 0..15 = 0..15, ready high, single-cycle valid
        push_pkt(1'b0);
        for (int i = 0; i < 16; i++) ew[i] = 32'(i);
        pkt_q.delete();
        push_pkt(1'b0);
        fill(32'h0, 1'b0, 0, 15);
        rd(8'h80, 32'h00);
        chk32("valid pulse length", 32'(last_hold), 32'd1);
        rd(8'h3C, 32'h0000000F);
        rd(8'h90, 32'h0);

        // Held packet with last flag, consumer stalls
        packet_data_ready = 1'b0;
        for (int i = 0; i < 16; i++) ew[i] = 32'h1000 + i;
        push_pkt(1'b1);
        fill(32'h1000, 1'b1, 0, 15);
        rd(8'h80, 32'h1F);
        rd(8'h0C, 32'h1003);
        repeat (3) @(posedge HCLK);
        #1 packet_data_ready = 1'b1;
        repeat (2) @(posedge HCLK);
        chk32("hold length >= 5", {31'd0, last_hold >= 5}, 32'd1);
        rd(8'h80, 32'h00);

        // Write while held stalls until the handshake, then lands in the new block
        packet_data_ready = 1'b0;
        for (int i = 0; i < 16; i++) ew[i] = 32'h2000 + i;
        push_pkt(1'b0);
        fill(32'h2000, 1'b0, 0, 15);
        fork
            xfer(1'b1, 8'h00, 32'hA5A5A5A5, 3'b010, st);
            begin
                int k;
                k = 0;
                do begin @(negedge HCLK); k++; end while (HREADYOUTS && k < 20);
                @(posedge HCLK);
                @(posedge HCLK); #1;
                packet_data_ready = 1'b1;
            end
        join
        chk32("stall cycles", 32'(st), 32'd3);
        rd(8'h80, 32'h01);
        rd(8'h00, 32'hA5A5A5A5);

        // Reset during a stalled write in HOLD
        #1 packet_data_ready = 1'b0;
        fill(32'h4000, 1'b0, 1, 15);
        fork
            xfer(1'b1, 8'h04, 32'h12345678, 3'b010, st);
            begin
                int k;
                k = 0;
                do begin @(negedge HCLK); k++; end while (HREADYOUTS && k < 20);
                @(posedge HCLK); #1;
                @(negedge HCLK); #2;
                HRESET = 1'b1;
                #1;
                chk32("async reset valid", {31'd0, packet_data_valid}, 32'd0);
                chk32("async reset HREADYOUTS", {31'd0, HREADYOUTS}, 32'd1);
                chk32("async reset packet_data nonzero", {31'd0, |packet_data}, 32'd0);
            end
        join
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        packet_data_ready = 1'b1;
        rd(8'h80, 32'h00);

        // Byte-sized write to word 15
        fill(32'h3000, 1'b0, 0, 14);
`ifdef PKT_CONSTRUCTOR_SIZE_CHECK_EN
        rsp_q.push_back('{is_err: 1'b1, data: 32'h0});
        xfer(1'b1, 8'h3C, 32'hDEADBEEF, 3'b000, st);
        chk32("size error valid", {31'd0, packet_data_valid}, 32'd0);
        rd(8'h80, 32'h0F);
        rd(8'h3C, 32'h0);
`else
        ew[15] = 32'hDEADBEEF;
        push_pkt(1'b0);
        xfer(1'b1, 8'h3C, 32'hDEADBEEF, 3'b000, st);
        rd(8'h80, 32'h00);
`endif

        repeat (5) @(posedge HCLK);
        chk32("packets left unseen", 32'(pkt_q.size()), 32'd0);
        chk32("responses left unseen", 32'(rsp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1);
    end

endmodule
`default_nettype wire
